// File: rtl/sobel_word_window.sv
// Sobel edge-magnitude stage: one centre column word (4 pixels x 3 rows) held at a time,
// horizontal neighbours taken from the previous/next word, 4 magnitude pixels out per word.
module sobel_word_window #(
  parameter int MAG_SHIFT = 0,
  parameter int THRESHOLD = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_first,
  input  logic        in_last,
  input  logic [31:0] in_top,
  input  logic [31:0] in_mid,
  input  logic [31:0] in_bot,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        out_first,
  output logic        out_last,
  output logic        err,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] c_top_q, c_top_d, c_mid_q, c_mid_d, c_bot_q, c_bot_d;
  logic [7:0]  l_top_q, l_top_d, l_mid_q, l_mid_d, l_bot_q, l_bot_d;
  logic        first_q, first_d;
  logic        err_q, err_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q, out_data_d;
  logic        out_first_q, out_first_d;
  logic        out_last_q, out_last_d;

  logic        beat, compute, new_line;
  logic [7:0]  r_top, r_mid, r_bot;
  logic [47:0] ext_t, ext_m, ext_b;
  logic [31:0] pix;

  function automatic logic [7:0] sobel_pix(input logic [7:0] tl, tc, tr, ml, mr, bl, bc, br);
    logic [11:0] sum_l, sum_r, sum_t, sum_b, gx, gy, ax, ay, mag, s;
    sum_l = {4'd0, tl} + {3'd0, ml, 1'b0} + {4'd0, bl};
    sum_r = {4'd0, tr} + {3'd0, mr, 1'b0} + {4'd0, br};
    sum_t = {4'd0, tl} + {3'd0, tc, 1'b0} + {4'd0, tr};
    sum_b = {4'd0, bl} + {3'd0, bc, 1'b0} + {4'd0, br};
    // Differences fit in 12-bit two's complement (+/-1020), so bit 11 is the sign.
    gx  = sum_r - sum_l;
    gy  = sum_b - sum_t;
    ax  = gx[11] ? (12'd0 - gx) : gx;
    ay  = gy[11] ? (12'd0 - gy) : gy;
    mag = ax + ay;
    s   = mag >> MAG_SHIFT;
    if (THRESHOLD > 0) sobel_pix = (int'(s) >= THRESHOLD) ? 8'hFF : 8'h00;
    else               sobel_pix = (s > 12'd255) ? 8'hFF : s[7:0];
  endfunction

  // Handshake: a beat transfers on a rising edge where in_valid && in_ready; in_ready is a
  // function of state only (low only in FLUSH). The output side has no backpressure.
  assign in_ready = (state_q != ST_FLUSH);
  assign beat     = in_valid && in_ready;
  assign compute  = (state_q == ST_FLUSH) || ((state_q == ST_HOLD) && beat && !in_first);
  assign new_line = (state_q == ST_EMPTY) || in_first;

  // Right neighbour: replicated byte3 at end of line, otherwise byte0 of the incoming word.
  assign r_top = (state_q == ST_FLUSH) ? c_top_q[31:24] : in_top[7:0];
  assign r_mid = (state_q == ST_FLUSH) ? c_mid_q[31:24] : in_mid[7:0];
  assign r_bot = (state_q == ST_FLUSH) ? c_bot_q[31:24] : in_bot[7:0];
  assign ext_t = {r_top, c_top_q, l_top_q};
  assign ext_m = {r_mid, c_mid_q, l_mid_q};
  assign ext_b = {r_bot, c_bot_q, l_bot_q};

  always_comb begin
    pix = '0;
    for (int i = 0; i < 4; i++) begin
      pix[8*i +: 8] = sobel_pix(ext_t[8*i +: 8], ext_t[8*i+8 +: 8], ext_t[8*i+16 +: 8],
                                ext_m[8*i +: 8], ext_m[8*i+16 +: 8],
                                ext_b[8*i +: 8], ext_b[8*i+8 +: 8], ext_b[8*i+16 +: 8]);
    end
  end

  always_comb begin
    state_d     = state_q;
    c_top_d     = c_top_q;
    c_mid_d     = c_mid_q;
    c_bot_d     = c_bot_q;
    l_top_d     = l_top_q;
    l_mid_d     = l_mid_q;
    l_bot_d     = l_bot_q;
    first_d     = first_q;
    err_d       = err_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_first_d = 1'b0;
    out_last_d  = 1'b0;

    if (compute) begin
      out_valid_d = 1'b1;
      out_data_d  = pix;
      out_first_d = first_q;
      out_last_d  = (state_q == ST_FLUSH);
    end

    case (state_q)
      ST_EMPTY, ST_HOLD: begin
        if (beat) begin
          if (((state_q == ST_EMPTY) && !in_first) || ((state_q == ST_HOLD) && in_first))
            err_d = 1'b1;
          if (new_line) begin
            l_top_d = in_top[7:0];
            l_mid_d = in_mid[7:0];
            l_bot_d = in_bot[7:0];
          end else begin
            l_top_d = c_top_q[31:24];
            l_mid_d = c_mid_q[31:24];
            l_bot_d = c_bot_q[31:24];
          end
          first_d = new_line;
          c_top_d = in_top;
          c_mid_d = in_mid;
          c_bot_d = in_bot;
          state_d = in_last ? ST_FLUSH : ST_HOLD;
        end
      end
      ST_FLUSH: begin
        first_d = 1'b0;
        state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      c_top_q     <= '0;
      c_mid_q     <= '0;
      c_bot_q     <= '0;
      l_top_q     <= '0;
      l_mid_q     <= '0;
      l_bot_q     <= '0;
      first_q     <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      c_top_q     <= c_top_d;
      c_mid_q     <= c_mid_d;
      c_bot_q     <= c_bot_d;
      l_top_q     <= l_top_d;
      l_mid_q     <= l_mid_d;
      l_bot_q     <= l_bot_d;
      first_q     <= first_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_first = out_first_q;
  assign out_last  = out_last_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sobel_word_window.sv
// Bench for sobel_word_window: three instances (default, MAG_SHIFT=2, THRESHOLD=5) share stimulus;
// expected words {first,last,data} are queued at drive time and compared against captured outputs.
module tb_sobel_word_window;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_first, in_last;
  logic [31:0] in_top, in_mid, in_bot;
  logic        in_ready, in_ready1, in_ready2;
  logic        ov0, ov1, ov2, of0, of1, of2, ol0, ol1, ol2, err0, err1, err2;
  logic [31:0] od0, od1, od2;
  logic [1:0]  st0, st1, st2;

  int checks = 0;
  int failures = 0;

  logic [33:0] exp0_q[$], exp1_q[$], exp2_q[$];
  logic [33:0] got0_q[$], got1_q[$], got2_q[$];
  logic [31:0] line_t[16], line_m[16], line_b[16];

  always #5 clk = ~clk;

  sobel_word_window #(.MAG_SHIFT(0), .THRESHOLD(0)) d0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first),
    .in_last(in_last), .in_top(in_top), .in_mid(in_mid), .in_bot(in_bot), .out_valid(ov0),
    .out_data(od0), .out_first(of0), .out_last(ol0), .err(err0), .dbg_state(st0));
  sobel_word_window #(.MAG_SHIFT(2), .THRESHOLD(0)) d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .in_first(in_first),
    .in_last(in_last), .in_top(in_top), .in_mid(in_mid), .in_bot(in_bot), .out_valid(ov1),
    .out_data(od1), .out_first(of1), .out_last(ol1), .err(err1), .dbg_state(st1));
  sobel_word_window #(.MAG_SHIFT(0), .THRESHOLD(5)) d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2), .in_first(in_first),
    .in_last(in_last), .in_top(in_top), .in_mid(in_mid), .in_bot(in_bot), .out_valid(ov2),
    .out_data(od2), .out_first(of2), .out_last(ol2), .err(err2), .dbg_state(st2));

  always @(negedge clk) begin
    if (ov0) got0_q.push_back({of0, ol0, od0});
    if (ov1) got1_q.push_back({of1, ol1, od1});
    if (ov2) got2_q.push_back({of2, ol2, od2});
  end

  // Reference model: image-row view with replicated horizontal borders.
  function automatic logic [7:0] get_px(input int row, input int p);
    logic [31:0] w;
    w = (row == 0) ? line_t[p/4] : (row == 1) ? line_m[p/4] : line_b[p/4];
    return w[8*(p%4) +: 8];
  endfunction

  function automatic logic [7:0] ref_px(input int n, input int p, input int shift, input int thr);
    int pl, pr, gx, gy, mag, s;
    pl = (p == 0) ? p : p - 1;
    pr = (p == 4*n - 1) ? p : p + 1;
    gx = (get_px(0, pr) + 2*get_px(1, pr) + get_px(2, pr)) - (get_px(0, pl) + 2*get_px(1, pl) + get_px(2, pl));
    gy = (get_px(2, pl) + 2*get_px(2, p) + get_px(2, pr)) - (get_px(0, pl) + 2*get_px(0, p) + get_px(0, pr));
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    s = mag >> shift;
    if (thr > 0) return (s >= thr) ? 8'hFF : 8'h00;
    return (s > 255) ? 8'hFF : 8'(s);
  endfunction

  task automatic model_line(input int n);
    logic [31:0] w0, w1, w2;
    for (int w = 0; w < n; w++) begin
      for (int k = 0; k < 4; k++) begin
        w0[8*k +: 8] = ref_px(n, 4*w + k, 0, 0);
        w1[8*k +: 8] = ref_px(n, 4*w + k, 2, 0);
        w2[8*k +: 8] = ref_px(n, 4*w + k, 0, 5);
      end
      exp0_q.push_back({w == 0, w == n - 1, w0});
      exp1_q.push_back({w == 0, w == n - 1, w1});
      exp2_q.push_back({w == 0, w == n - 1, w2});
    end
  endtask

  task automatic send_beat(input logic f, input logic l, input logic [31:0] t, input logic [31:0] m,
                           input logic [31:0] b);
    int waited = 0;
    in_first = f; in_last = l; in_top = t; in_mid = m; in_bot = b; in_valid = 1'b1;
    while (!in_ready && waited < 16) begin
      @(posedge clk); #1; waited++;
    end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL ready_timeout in_ready=%b required=1", in_ready);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_line(input int n, input bit gaps);
    for (int w = 0; w < n; w++) begin
      send_beat(w == 0, w == n - 1, line_t[w], line_m[w], line_b[w]);
      if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(posedge clk);
      #0;
    end
  endtask

  task automatic fill_line(input int n, input logic [31:0] t, input logic [31:0] m, input logic [31:0] b);
    for (int w = 0; w < n; w++) begin
      line_t[w] = t; line_m[w] = m; line_b[w] = b;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic clear_queues();
    exp0_q.delete(); exp1_q.delete(); exp2_q.delete();
    got0_q.delete(); got1_q.delete(); got2_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_first = 1'b1; in_last = 1'b0;
    in_top = 32'hFFFFFFFF; in_mid = 32'h0; in_bot = 32'h12345678;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({ov0, of0, ol0, err0, in_ready} !== 5'b00001 || od0 !== 32'h0 || st0 !== 2'd0) begin
      failures++;
      $display("FAIL reset_state v/f/l/err/rdy=%b data=%h st=%0d required 00001 00000000 0",
               {ov0, of0, ol0, err0, in_ready}, od0, st0);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    clear_queues();
  endtask

  task automatic test_flat_line();
    logic [33:0] e, g;
    clear_queues();
    fill_line(3, 32'h80808080, 32'h80808080, 32'h80808080);
    exp0_q.push_back({1'b1, 1'b0, 32'h0});
    exp0_q.push_back({1'b0, 1'b0, 32'h0});
    exp0_q.push_back({1'b0, 1'b1, 32'h0});
    send_beat(1'b1, 1'b0, line_t[0], line_m[0], line_b[0]);
    send_beat(1'b0, 1'b0, line_t[1], line_m[1], line_b[1]);
    send_beat(1'b0, 1'b1, line_t[2], line_m[2], line_b[2]);
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL flat_ready_low in_ready=%b required=0", in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL flat_ready_back in_ready=%b required=1", in_ready);
    end
    repeat (4) @(posedge clk); #1;
    checks++;
    if (got0_q.size() != exp0_q.size()) begin
      failures++; $display("FAIL flat_count got=%0d required=%0d", got0_q.size(), exp0_q.size());
    end
    while (exp0_q.size() > 0 && got0_q.size() > 0) begin
      e = exp0_q.pop_front(); g = got0_q.pop_front(); checks++;
      if (g !== e) begin
        failures++; $display("FAIL flat_word got=%h required=%h", g, e);
      end
    end
  endtask

  task automatic test_one_word();
    logic [33:0] e, g;
    clear_queues();
    exp0_q.push_back({1'b1, 1'b1, 32'h00FFFF00});
    send_beat(1'b1, 1'b1, 32'hFFFF0000, 32'hFFFF0000, 32'hFFFF0000);
    checks++;
    if (ov0 !== 1'b0) begin
      failures++; $display("FAIL one_word_early out_valid=%b required=0", ov0);
    end
    @(posedge clk); #1;
    checks++;
    if ({ov0, of0, ol0} !== 3'b111 || od0 !== 32'h00FFFF00) begin
      failures++;
      $display("FAIL one_word_latency v/f/l=%b data=%h required 111 00FFFF00", {ov0, of0, ol0}, od0);
    end
    repeat (3) @(posedge clk); #1;
    checks++;
    if (got0_q.size() != 1) begin
      failures++; $display("FAIL one_word_count got=%0d required=1", got0_q.size());
    end
    while (exp0_q.size() > 0 && got0_q.size() > 0) begin
      e = exp0_q.pop_front(); g = got0_q.pop_front(); checks++;
      if (g !== e) begin
        failures++; $display("FAIL one_word_word got=%h required=%h", g, e);
      end
    end
  endtask

  task automatic test_scale_threshold();
    clear_queues();
    send_beat(1'b1, 1'b1, 32'h0, 32'h0, 32'h01010101);
    repeat (2) @(posedge clk);
    send_beat(1'b1, 1'b1, 32'h0, 32'h0, 32'h02020202);
    repeat (4) @(posedge clk); #1;
    checks++;
    if (got0_q.size() != 2 || got1_q.size() != 2 || got2_q.size() != 2) begin
      failures++;
      $display("FAIL scale_count got=%0d/%0d/%0d required=2/2/2", got0_q.size(), got1_q.size(), got2_q.size());
    end else begin
      checks++;
      if (got0_q[0] !== {2'b11, 32'h04040404}) begin
        failures++; $display("FAIL grey_bot1 got=%h required=%h", got0_q[0], {2'b11, 32'h04040404});
      end
      checks++;
      if (got1_q[0] !== {2'b11, 32'h01010101}) begin
        failures++; $display("FAIL shift2_bot1 got=%h required=%h", got1_q[0], {2'b11, 32'h01010101});
      end
      checks++;
      if (got2_q[0] !== {2'b11, 32'h00000000}) begin
        failures++; $display("FAIL thr_below got=%h required=%h", got2_q[0], {2'b11, 32'h0});
      end
      checks++;
      if (got2_q[1] !== {2'b11, 32'hFFFFFFFF}) begin
        failures++; $display("FAIL thr_above got=%h required=%h", got2_q[1], {2'b11, 32'hFFFFFFFF});
      end
      checks++;
      if (got0_q[1] !== {2'b11, 32'h08080808}) begin
        failures++; $display("FAIL grey_bot2 got=%h required=%h", got0_q[1], {2'b11, 32'h08080808});
      end
    end
  endtask

  task automatic test_step_edge();
    logic [33:0] e, g;
    clear_queues();
    line_t[0] = 32'h0; line_m[0] = 32'h0; line_b[0] = 32'h0;
    line_t[1] = 32'hFFFFFFFF; line_m[1] = 32'hFFFFFFFF; line_b[1] = 32'hFFFFFFFF;
    exp0_q.push_back({1'b1, 1'b0, 32'hFF000000});
    exp0_q.push_back({1'b0, 1'b1, 32'h000000FF});
    send_line(2, 1'b0);
    repeat (4) @(posedge clk); #1;
    checks++;
    if (got0_q.size() != exp0_q.size()) begin
      failures++; $display("FAIL step_count got=%0d required=%0d", got0_q.size(), exp0_q.size());
    end
    while (exp0_q.size() > 0 && got0_q.size() > 0) begin
      e = exp0_q.pop_front(); g = got0_q.pop_front(); checks++;
      if (g !== e) begin
        failures++; $display("FAIL step_word got=%h required=%h", g, e);
      end
    end
  endtask

  task automatic test_mid_reset();
    clear_queues();
    send_beat(1'b1, 1'b0, $urandom, $urandom, $urandom);
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ov0 !== 1'b0 || in_ready !== 1'b1 || st0 !== 2'd0) begin
      failures++;
      $display("FAIL mid_reset out_valid=%b in_ready=%b st=%0d required 0 1 0", ov0, in_ready, st0);
    end
    rst_n = 1'b1;
    repeat (4) @(posedge clk); #1;
    checks++;
    if (got0_q.size() != 0 || err0 !== 1'b0) begin
      failures++; $display("FAIL mid_reset_stale outputs=%0d err=%b required 0 0", got0_q.size(), err0);
    end
  endtask

  task automatic test_protocol_err();
    logic [33:0] e, g;
    clear_queues();
    send_beat(1'b1, 1'b0, $urandom, $urandom, $urandom);
    fill_line(3, 32'h80808080, 32'h80808080, 32'h80808080);
    exp0_q.push_back({1'b1, 1'b0, 32'h0});
    exp0_q.push_back({1'b0, 1'b0, 32'h0});
    exp0_q.push_back({1'b0, 1'b1, 32'h0});
    send_line(3, 1'b0);
    repeat (4) @(posedge clk); #1;
    checks++;
    if (err0 !== 1'b1) begin
      failures++; $display("FAIL err_hold_first err=%b required=1", err0);
    end
    checks++;
    if (got0_q.size() != exp0_q.size()) begin
      failures++; $display("FAIL err_count got=%0d required=%0d", got0_q.size(), exp0_q.size());
    end
    while (exp0_q.size() > 0 && got0_q.size() > 0) begin
      e = exp0_q.pop_front(); g = got0_q.pop_front(); checks++;
      if (g !== e) begin
        failures++; $display("FAIL err_word got=%h required=%h", g, e);
      end
    end
    do_reset();
    clear_queues();
    send_beat(1'b0, 1'b1, 32'hFFFF0000, 32'hFFFF0000, 32'hFFFF0000);
    repeat (4) @(posedge clk); #1;
    checks++;
    if (err0 !== 1'b1 || got0_q.size() != 1) begin
      failures++; $display("FAIL err_empty_nofirst err=%b outputs=%0d required 1 1", err0, got0_q.size());
    end else begin
      checks++;
      if (got0_q[0] !== {2'b11, 32'h00FFFF00}) begin
        failures++; $display("FAIL err_empty_word got=%h required=%h", got0_q[0], {2'b11, 32'h00FFFF00});
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [33:0] e, g;
    int n;
    do_reset();
    clear_queues();
    for (int ln = 0; ln < 8; ln++) begin
      n = $urandom_range(1, 6);
      for (int w = 0; w < n; w++) begin
        line_t[w] = $urandom; line_m[w] = $urandom;
        line_b[w] = (ln % 2 == 0) ? $urandom : (line_t[w] ^ 32'h01010101);
      end
      model_line(n);
      send_line(n, ln >= 4);
    end
    repeat (6) @(posedge clk); #1;
    checks++;
    if (got0_q.size() != exp0_q.size() || got1_q.size() != exp1_q.size() || got2_q.size() != exp2_q.size()) begin
      failures++;
      $display("FAIL b2b_count got=%0d/%0d/%0d required=%0d/%0d/%0d", got0_q.size(), got1_q.size(),
               got2_q.size(), exp0_q.size(), exp1_q.size(), exp2_q.size());
    end
    while (exp0_q.size() > 0 && got0_q.size() > 0) begin
      e = exp0_q.pop_front(); g = got0_q.pop_front(); checks++;
      if (g !== e) begin
        failures++; $display("FAIL b2b_grey got=%h required=%h", g, e);
      end
    end
    while (exp1_q.size() > 0 && got1_q.size() > 0) begin
      e = exp1_q.pop_front(); g = got1_q.pop_front(); checks++;
      if (g !== e) begin
        failures++; $display("FAIL b2b_shift2 got=%h required=%h", g, e);
      end
    end
    while (exp2_q.size() > 0 && got2_q.size() > 0) begin
      e = exp2_q.pop_front(); g = got2_q.pop_front(); checks++;
      if (g !== e) begin
        failures++; $display("FAIL b2b_thr got=%h required=%h", g, e);
      end
    end
    checks++;
    if (err0 !== 1'b0) begin
      failures++; $display("FAIL b2b_err err=%b required=0", err0);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    in_top = '0; in_mid = '0; in_bot = '0;
    test_reset();
    test_flat_line();
    test_one_word();
    test_scale_threshold();
    test_step_edge();
    test_mid_reset();
    test_protocol_err();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
